// File: rtl/rst_req_ctrl.sv
// Reset request controller: arbitrates debug, programmer, watchdog and software
// reset requests into stretched, cooldown-separated ndmreset / prog_rst_n pulses.
module rst_req_ctrl #(
    parameter int unsigned STRETCH_CYCLES  = 16,
    parameter int unsigned COOLDOWN_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       dbg_ndmreset_i,
    input  logic       prog_req_i,
    input  logic       wdog_bite_i,
    input  logic       sw_rst_req_i,
    input  logic       cause_clr_i,
    output logic       ndmreset_o,
    output logic       prog_rst_no,
    output logic       busy_o,
    output logic [3:0] cause_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_HOLD,
        ST_COOLDOWN
    } state_e;

    typedef enum logic {
        KIND_NDM,
        KIND_PROG
    } kind_e;

    localparam logic [7:0] STRETCH_LOAD  = 8'(STRETCH_CYCLES - 1);
    localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_CYCLES - 1);

    state_e     state;
    kind_e      kind;
    logic       level_src;
    logic [7:0] cnt;
    logic       wdog_pend;
    logic       sw_pend;

    logic       wdog_req;
    logic       sw_req;
    logic       any_req;
    logic       level_high;

    assign wdog_req   = wdog_pend | wdog_bite_i;
    assign sw_req     = sw_pend | sw_rst_req_i;
    assign any_req    = dbg_ndmreset_i | prog_req_i | wdog_req | sw_req;
    // Only meaningful for level grants: PROG came from the programmer, NDM from debug.
    assign level_high = (kind == KIND_PROG) ? prog_req_i : dbg_ndmreset_i;

    // Outputs are assigned on each transition so they are registered and track
    // the state they belong to from the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            kind        <= KIND_NDM;
            level_src   <= 1'b0;
            cnt         <= '0;
            wdog_pend   <= 1'b0;
            sw_pend     <= 1'b0;
            ndmreset_o  <= 1'b0;
            prog_rst_no <= 1'b1;
            busy_o      <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; the later grant-clear below overrides
            // this capture because the last scheduled update in the block wins.
            wdog_pend <= wdog_req;
            sw_pend   <= sw_req;

            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state  <= ST_ASSERT;
                        cnt    <= STRETCH_LOAD;
                        busy_o <= 1'b1;
                        if (dbg_ndmreset_i) begin
                            kind       <= KIND_NDM;
                            level_src  <= 1'b1;
                            ndmreset_o <= 1'b1;
                        end else if (prog_req_i) begin
                            kind        <= KIND_PROG;
                            level_src   <= 1'b1;
                            prog_rst_no <= 1'b0;
                        end else if (wdog_req) begin
                            kind       <= KIND_NDM;
                            level_src  <= 1'b0;
                            ndmreset_o <= 1'b1;
                            wdog_pend  <= 1'b0;
                        end else begin
                            kind       <= KIND_NDM;
                            level_src  <= 1'b0;
                            ndmreset_o <= 1'b1;
                            sw_pend    <= 1'b0;
                        end
                    end
                end

                ST_ASSERT: begin
                    if (cnt == 8'd0) begin
                        // Skip HOLD when the level source already dropped so the
                        // reset is exactly the minimum width.
                        if (level_src && level_high) begin
                            state <= ST_HOLD;
                        end else begin
                            state       <= ST_COOLDOWN;
                            cnt         <= COOLDOWN_LOAD;
                            ndmreset_o  <= 1'b0;
                            prog_rst_no <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                ST_HOLD: begin
                    if (!level_high) begin
                        state       <= ST_COOLDOWN;
                        cnt         <= COOLDOWN_LOAD;
                        ndmreset_o  <= 1'b0;
                        prog_rst_no <= 1'b1;
                    end
                end

                ST_COOLDOWN: begin
                    if (cnt == 8'd0) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    ndmreset_o  <= 1'b0;
                    prog_rst_no <= 1'b1;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

    // Set has priority over clear so a cause arriving with the clear is kept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cause_o <= 4'b0000;
        end else begin
            cause_o <= (cause_o & ~{4{cause_clr_i}})
                     | {dbg_ndmreset_i, prog_req_i, wdog_bite_i, sw_rst_req_i};
        end
    end

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Self-checking bench for rst_req_ctrl: directed scenarios plus randomized
// episodes checked against width/gap rules computed from the request pattern.
module tb_rst_req_ctrl;

    localparam int S = 16;
    localparam int C = 4;

    localparam int SRC_SW   = 0;
    localparam int SRC_WDOG = 1;
    localparam int SRC_PROG = 2;
    localparam int SRC_DBG  = 3;
    localparam int SRC_PEND = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       dbg_ndmreset_i;
    logic       prog_req_i;
    logic       wdog_bite_i;
    logic       sw_rst_req_i;
    logic       cause_clr_i;
    logic       ndmreset_o;
    logic       prog_rst_no;
    logic       busy_o;
    logic [3:0] cause_o;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_cause;

    rst_req_ctrl #(
        .STRETCH_CYCLES (S),
        .COOLDOWN_CYCLES(C)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .dbg_ndmreset_i(dbg_ndmreset_i),
        .prog_req_i    (prog_req_i),
        .wdog_bite_i   (wdog_bite_i),
        .sw_rst_req_i  (sw_rst_req_i),
        .cause_clr_i   (cause_clr_i),
        .ndmreset_o    (ndmreset_o),
        .prog_rst_no   (prog_rst_no),
        .busy_o        (busy_o),
        .cause_o       (cause_o)
    );

    always #5 clk_i = ~clk_i;

    // Sticky cause reference: a bit is set whenever its source is seen high,
    // cleared by a clear pulse unless its source is high in that same cycle.
    always @(posedge clk_i) begin
        if (rst_i) exp_cause <= 4'b0000;
        else       exp_cause <= (exp_cause & ~{4{cause_clr_i}})
                              | {dbg_ndmreset_i, prog_req_i, wdog_bite_i, sw_rst_req_i};
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit active();
        return (ndmreset_o === 1'b1) || (prog_rst_no === 1'b0);
    endfunction

    task automatic do_reset();
        rst_i          = 1'b1;
        dbg_ndmreset_i = 1'b0;
        prog_req_i     = 1'b0;
        wdog_bite_i    = 1'b0;
        sw_rst_req_i   = 1'b0;
        cause_clr_i    = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // One full reset episode from an idle controller: grant latency, polarity,
    // active width, cooldown length and busy release. Level sources are held
    // high for h sampled edges starting at the grant edge.
    task automatic run_episode(input string name, input int src, input int h,
                               input bit with_wdog, input int cd_pulse_at);
        bit exp_ndm;
        int exp_w;
        int w;
        int cd;
        int j;
        bit pol_err;
        exp_ndm = (src != SRC_PROG);
        if (src == SRC_PROG || src == SRC_DBG) exp_w = (h > S) ? h : S;
        else                                   exp_w = S;

        case (src)
            SRC_SW:   sw_rst_req_i   = 1'b1;
            SRC_WDOG: wdog_bite_i    = 1'b1;
            SRC_PROG: prog_req_i     = 1'b1;
            SRC_DBG:  dbg_ndmreset_i = 1'b1;
            default: ;
        endcase
        if (with_wdog) wdog_bite_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        wdog_bite_i  = 1'b0;

        total++;
        if (!(active() && busy_o === 1'b1)) begin
            bad++;
            $display("FAIL %s grant_latency: active=%0b busy=%b want active=1 busy=1",
                     name, active(), busy_o);
        end

        w       = 0;
        j       = 1;
        pol_err = 1'b0;
        while (active() && w < 300) begin
            if (exp_ndm  && !(ndmreset_o === 1'b1 && prog_rst_no === 1'b1)) pol_err = 1'b1;
            if (!exp_ndm && !(ndmreset_o === 1'b0 && prog_rst_no === 1'b0)) pol_err = 1'b1;
            if (src == SRC_PROG) prog_req_i     = (j < h);
            if (src == SRC_DBG)  dbg_ndmreset_i = (j < h);
            w++;
            tick();
            j++;
        end
        prog_req_i     = 1'b0;
        dbg_ndmreset_i = 1'b0;

        total++;
        if (pol_err) begin
            bad++;
            $display("FAIL %s polarity: wrong output active (ndm=%b prog_n=%b) want ndm_kind=%0b",
                     name, ndmreset_o, prog_rst_no, exp_ndm);
        end
        total++;
        if (w != exp_w) begin
            bad++;
            $display("FAIL %s width: got %0d cycles want %0d", name, w, exp_w);
        end

        cd = 0;
        while (busy_o === 1'b1 && !active() && cd < 300) begin
            if (cd == cd_pulse_at) sw_rst_req_i = 1'b1;
            cd++;
            tick();
            sw_rst_req_i = 1'b0;
        end
        total++;
        if (cd != C || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL %s cooldown: got %0d cycles busy=%b want %0d cycles busy=0",
                     name, cd, busy_o, C);
        end
    endtask

    task automatic test_reset();
        rst_i          = 1'b1;
        dbg_ndmreset_i = 1'b1;
        prog_req_i     = 1'b1;
        wdog_bite_i    = 1'b1;
        sw_rst_req_i   = 1'b1;
        cause_clr_i    = 1'b0;
        repeat (3) tick();
        total++;
        if (ndmreset_o !== 1'b0 || prog_rst_no !== 1'b1 || busy_o !== 1'b0 || cause_o !== 4'b0000) begin
            bad++;
            $display("FAIL reset_values: ndm=%b prog_n=%b busy=%b cause=%b want 0 1 0 0000",
                     ndmreset_o, prog_rst_no, busy_o, cause_o);
        end
        do_reset();
        tick();
        total++;
        if (busy_o !== 1'b0 || cause_o !== 4'b0000) begin
            bad++;
            $display("FAIL reset_release_idle: busy=%b cause=%b want 0 0000", busy_o, cause_o);
        end
    endtask

    task automatic test_sw_pulse();
        do_reset();
        run_episode("sw_pulse", SRC_SW, 0, 1'b0, -1);
        total++;
        if (cause_o !== 4'b0001) begin
            bad++;
            $display("FAIL sw_cause: got %b want 0001", cause_o);
        end
    endtask

    task automatic test_prog_level();
        do_reset();
        run_episode("prog_40", SRC_PROG, 40, 1'b0, -1);
        run_episode("prog_5",  SRC_PROG, 5,  1'b0, -1);
        run_episode("prog_16", SRC_PROG, 16, 1'b0, -1);
        run_episode("dbg_17",  SRC_DBG,  17, 1'b0, -1);
        total++;
        if (cause_o !== exp_cause || cause_o !== 4'b1100) begin
            bad++;
            $display("FAIL level_cause: got %b want 1100", cause_o);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        run_episode("dbg_with_wdog", SRC_DBG, 3, 1'b1, -1);
        run_episode("wdog_pending", SRC_PEND, 0, 1'b0, -1);
        total++;
        if (cause_o !== 4'b1010) begin
            bad++;
            $display("FAIL simultaneous_cause: got %b want 1010", cause_o);
        end
    endtask

    task automatic test_cooldown_clear();
        do_reset();
        run_episode("sw_then_cd_pulse", SRC_SW, 0, 1'b0, 1);
        run_episode("sw_pending", SRC_PEND, 0, 1'b0, -1);
        cause_clr_i = 1'b1;
        wdog_bite_i = 1'b1;
        tick();
        cause_clr_i = 1'b0;
        wdog_bite_i = 1'b0;
        total++;
        if (cause_o !== 4'b0010) begin
            bad++;
            $display("FAIL clear_vs_set: got %b want 0010", cause_o);
        end
        cause_clr_i = 1'b1;
        tick();
        cause_clr_i = 1'b0;
        total++;
        if (cause_o !== 4'b0000) begin
            bad++;
            $display("FAIL clear_only: got %b want 0000", cause_o);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        do_reset();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        wdog_bite_i  = 1'b1;
        tick();
        wdog_bite_i  = 1'b0;
        repeat (6) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        total++;
        if (ndmreset_o !== 1'b0 || prog_rst_no !== 1'b1 || busy_o !== 1'b0 || cause_o !== 4'b0000) begin
            bad++;
            $display("FAIL mid_op_reset: ndm=%b prog_n=%b busy=%b cause=%b want 0 1 0 0000",
                     ndmreset_o, prog_rst_no, busy_o, cause_o);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy_o !== 1'b0 || active()) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_op_no_pending: busy/active for %0d cycles want 0", seen);
        end
    endtask

    task automatic test_random();
        int src;
        int h;
        do_reset();
        for (int it = 0; it < 16; it++) begin
            src = int'($urandom_range(0, 3));
            h   = int'($urandom_range(1, 40));
            repeat ($urandom_range(0, 5)) tick();
            run_episode($sformatf("rand%0d_src%0d_h%0d", it, src, h), src, h, 1'b0, -1);
            total++;
            if (cause_o !== exp_cause) begin
                bad++;
                $display("FAIL rand%0d_cause: got %b want %b", it, cause_o, exp_cause);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sw_pulse();
        test_prog_level();
        test_simultaneous();
        test_cooldown_clear();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
